// File: rtl/rose_impl_monitor.sv
// -----------------------------------------------------------------------------
// rose_impl_monitor
//
// Synthesizable checker for the implication "a |-> $rose(b)" (edge_sel = 1)
// or "a |-> $fell(b)" (edge_sel = 0). The check is evaluated on every rising
// clock edge. It lets the same check run on FPGA or in emulation, where SVA is
// not available.
//
// Each evaluated sample gives one of three results: pass, fail or vacuous
// (a = 0). Pass and fail produce one-cycle registered pulses. All three
// results are tallied in saturating counters. A free-running sample counter
// timestamps the first failure seen since reset or clear.
//
// Parameters
//   CNT_W          width of the pass/fail/vacuous counters (saturating)
//   CYC_W          width of the sample counter and first-fail timestamp
//
// Ports
//   clk            clock; all logic is on the rising edge
//   rst            synchronous active-high reset; has priority over clr and en
//   en             check enable; when low, nothing is evaluated or counted
//   clr            synchronous clear of counters, capture and pulses
//   edge_sel       1: consequent is a rise of b, 0: consequent is a fall of b
//   a              antecedent
//   b              consequent signal
//   pass_pulse     one-cycle pulse, in the cycle after a passing sample
//   fail_pulse     one-cycle pulse, in the cycle after a failing sample
//   pass_cnt       number of passes (saturating)
//   fail_cnt       number of failures (saturating)
//   vac_cnt        number of vacuous evaluations (saturating)
//   first_fail_vld sticky flag: at least one failure since rst/clr
//   first_fail_cyc cycle_cnt value of the first failing sample
//   cycle_cnt      sample counter; wraps, cleared by rst/clr
// -----------------------------------------------------------------------------
module rose_impl_monitor #(
    parameter int CNT_W = 16,
    parameter int CYC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             edge_sel,
    input  logic             a,
    input  logic             b,
    output logic             pass_pulse,
    output logic             fail_pulse,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] vac_cnt,
    output logic             first_fail_vld,
    output logic [CYC_W-1:0] first_fail_cyc,
    output logic [CYC_W-1:0] cycle_cnt
);

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    logic             b_q,          b_d;
    logic             pass_pulse_q, pass_pulse_d;
    logic             fail_pulse_q, fail_pulse_d;
    logic [CNT_W-1:0] pass_cnt_q,   pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q,   fail_cnt_d;
    logic [CNT_W-1:0] vac_cnt_q,    vac_cnt_d;
    logic             ff_vld_q,     ff_vld_d;
    logic [CYC_W-1:0] ff_cyc_q,     ff_cyc_d;
    logic [CYC_W-1:0] cyc_q,        cyc_d;

    logic rise;
    logic fall;
    logic hit;

    // b_q is the previous sample of b. After reset it is 0, so a b that is
    // already high on the first sample counts as a rise, matching $past.
    assign rise = b & ~b_q;
    assign fall = ~b & b_q;
    // The select is used combinationally, so a change applies to the same sample.
    assign hit  = edge_sel ? rise : fall;

    always_comb begin
        // Defaults: hold state, no pulse, track b, advance the sample counter.
        b_d          = b;
        pass_pulse_d = 1'b0;
        fail_pulse_d = 1'b0;
        pass_cnt_d   = pass_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        vac_cnt_d    = vac_cnt_q;
        ff_vld_d     = ff_vld_q;
        ff_cyc_d     = ff_cyc_q;
        cyc_d        = cyc_q + CYC_W'(1);

        if (clr) begin
            // Clear wipes results and the timestamp base. b_q keeps tracking
            // b (default above), so edge history survives a clear.
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            vac_cnt_d  = '0;
            ff_vld_d   = 1'b0;
            ff_cyc_d   = '0;
            cyc_d      = '0;
        end else if (en) begin
            if (!a) begin
                vac_cnt_d = sat_inc(vac_cnt_q);
            end else if (hit) begin
                pass_pulse_d = 1'b1;
                pass_cnt_d   = sat_inc(pass_cnt_q);
            end else begin
                fail_pulse_d = 1'b1;
                fail_cnt_d   = sat_inc(fail_cnt_q);
                // Capture only the first failure. The timestamp is the counter
                // value present at the sampling edge, before it advances.
                if (!ff_vld_q) begin
                    ff_vld_d = 1'b1;
                    ff_cyc_d = cyc_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_q          <= 1'b0;
            pass_pulse_q <= 1'b0;
            fail_pulse_q <= 1'b0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            vac_cnt_q    <= '0;
            ff_vld_q     <= 1'b0;
            ff_cyc_q     <= '0;
            cyc_q        <= '0;
        end else begin
            b_q          <= b_d;
            pass_pulse_q <= pass_pulse_d;
            fail_pulse_q <= fail_pulse_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            vac_cnt_q    <= vac_cnt_d;
            ff_vld_q     <= ff_vld_d;
            ff_cyc_q     <= ff_cyc_d;
            cyc_q        <= cyc_d;
        end
    end

    assign pass_pulse     = pass_pulse_q;
    assign fail_pulse     = fail_pulse_q;
    assign pass_cnt       = pass_cnt_q;
    assign fail_cnt       = fail_cnt_q;
    assign vac_cnt        = vac_cnt_q;
    assign first_fail_vld = ff_vld_q;
    assign first_fail_cyc = ff_cyc_q;
    assign cycle_cnt      = cyc_q;

endmodule
